fpu_shift_pipe: RTL and testbench



---
 rtl/fpu_shift_pkg.sv | 15 +
 rtl/fpu_shift_levels.sv | 63 ++++++
 rtl/fpu_shift_pipe.sv | 127 ++++++++++++
 tb/tb_fpu_shift_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_shift_pkg.sv
// Shared definitions for the FPU shift pipeline: mode encodings and the
// helper that splits the shift levels between the two pipeline stages.
package fpu_shift_pkg;

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_ASR = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Stage 1 covers levels 0 .. (shw/2)-1; stage 2 starts at the returned level.
  function automatic int stage2_first_level(input int shw);
    return shw / 32'sd2;
  endfunction

endpackage

// File: rtl/fpu_shift_levels.sv
// Combinational slice of the barrel shifter: applies shift levels LO..HI
// (level i moves the operand by 2^i when amt bit i is set) and reports
// whether any set bit was pushed off the end in those levels.
module fpu_shift_levels
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LO    = 0,
  parameter int HI    = 1
) (
  input  logic [WIDTH-1:0]         src,
  input  logic [$clog2(WIDTH)-1:0] amt,
  input  logic [1:0]               op,
  input  logic                     sign,
  output logic [WIDTH-1:0]         data,
  output logic                     sticky
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [SHW-1:0]   AMT_ONE = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   AMT_NIL = {SHW{1'b0}};

  logic [WIDTH-1:0] d_s;
  logic             st_s;

  // Walk the selected levels, shifting and collecting discarded bits.
  always_comb begin
    d_s  = src;
    st_s = 1'b0;
    for (int i = LO; i <= HI; i++) begin
      if ((amt & (AMT_ONE << i)) != AMT_NIL) begin
        case (op)
          OP_LSR: begin
            st_s = st_s | (|(d_s & ~(ONES << (32'd1 << i))));
            d_s  = d_s >> (32'd1 << i);
          end
          OP_ASR: begin
            st_s = st_s | (|(d_s & ~(ONES << (32'd1 << i))));
            d_s  = (d_s >> (32'd1 << i)) | (sign ? ~(ONES >> (32'd1 << i)) : ZERO);
          end
          OP_LSL: begin
            st_s = st_s | (|(d_s & ~(ONES >> (32'd1 << i))));
            d_s  = d_s << (32'd1 << i);
          end
          OP_ROR: begin
            d_s  = (d_s >> (32'd1 << i)) | (d_s << (WIDTH - (32'd1 << i)));
          end
          default: begin
            d_s  = d_s;
          end
        endcase
      end else begin
        st_s = st_s;
      end
    end
  end

  assign data   = d_s;
  assign sticky = st_s;

endmodule

// File: rtl/fpu_shift_pipe.sv
// Two-stage pipelined barrel shifter (LSR/ASR/LSL/ROR) with saturating
// shift amounts, sticky and zero flags, sideband tag and valid/ready flow
// control. Stage 1 holds partially shifted data; stage 2 is the output.
module fpu_shift_pipe
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH):0]   in_amt,
  input  logic [1:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sticky,
  output logic                     out_zero,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int S2_LO = stage2_first_level(SHW);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic             adv1_s;
  logic             adv2_s;

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_data_r;
  logic             s1_sticky_r;
  logic [1:0]       s1_op_r;
  logic [SHW:0]     s1_amt_r;
  logic             s1_sign_r;
  logic             s1_nz_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic [WIDTH-1:0] l1_data_s;
  logic             l1_sticky_s;
  logic [WIDTH-1:0] l2_data_s;
  logic             l2_sticky_s;
  logic [WIDTH-1:0] res_data_s;
  logic             res_sticky_s;

  // The output register frees up when empty or drained; stage 1 follows.
  assign adv2_s   = !out_valid || out_ready;
  assign adv1_s   = !s1_valid_r || adv2_s;
  assign in_ready = adv1_s;

  fpu_shift_levels #(.WIDTH(WIDTH), .LO(0), .HI(S2_LO - 1)) u_lvl1 (
    .src    (in_data),
    .amt    (in_amt[SHW-1:0]),
    .op     (in_op),
    .sign   (in_data[WIDTH-1]),
    .data   (l1_data_s),
    .sticky (l1_sticky_s)
  );

  fpu_shift_levels #(.WIDTH(WIDTH), .LO(S2_LO), .HI(SHW - 1)) u_lvl2 (
    .src    (s1_data_r),
    .amt    (s1_amt_r[SHW-1:0]),
    .op     (s1_op_r),
    .sign   (s1_sign_r),
    .data   (l2_data_s),
    .sticky (l2_sticky_s)
  );

  // Stage-1 payload; qualified by s1_valid_r so it carries no reset.
  always_ff @(posedge clk) begin
    if (adv1_s && in_valid) begin
      s1_data_r   <= l1_data_s;
      s1_sticky_r <= l1_sticky_s;
      s1_op_r     <= in_op;
      s1_amt_r    <= in_amt;
      s1_sign_r   <= in_data[WIDTH-1];
      s1_nz_r     <= |in_data;
      s1_tag_r    <= in_tag;
    end
  end

  // Final result: rotate ignores the amount MSB, other modes saturate on it.
  always_comb begin
    res_data_s   = l2_data_s;
    res_sticky_s = 1'b0;
    if (s1_op_r == OP_ROR) begin
      res_data_s   = l2_data_s;
      res_sticky_s = 1'b0;
    end else if (s1_amt_r[SHW]) begin
      res_data_s   = ((s1_op_r == OP_ASR) && s1_sign_r) ? ONES : ZERO;
      res_sticky_s = s1_nz_r;
    end else begin
      res_data_s   = l2_data_s;
      res_sticky_s = s1_sticky_r | l2_sticky_s;
    end
  end

  // Valid bits and output registers; outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= ZERO;
      out_sticky <= 1'b0;
      out_zero   <= 1'b0;
      out_tag    <= {TAG_W{1'b0}};
    end else begin
      if (adv1_s) begin
        s1_valid_r <= in_valid;
      end
      if (adv2_s) begin
        out_valid <= s1_valid_r;
        if (s1_valid_r) begin
          out_data   <= res_data_s;
          out_sticky <= res_sticky_s;
          out_zero   <= (res_data_s == ZERO);
          out_tag    <= s1_tag_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_shift_pipe.sv
// Bench for fpu_shift_pipe: directed table at WIDTH=16 (latency, flags,
// saturation, rotate modulo), a stalled stream, reset with beats in
// flight, and randomized traffic at WIDTH=8/32/64 against a plain
// arithmetic reference model.
module tb_fpu_shift_pipe;
  import fpu_shift_pkg::*;

  localparam int W  = 16;
  localparam int AW = 5;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] d;
    int          amt;
    logic [15:0] ed;
    logic        es;
    logic        ez;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        s;
    logic        z;
    logic [3:0]  tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic [1:0]    in_op;
  logic [3:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sticky;
  logic          out_zero;
  logic [3:0]    out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_shift_pipe #(.WIDTH(W), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky), .out_zero(out_zero), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: shift the whole operand at once by the requested amount.
  function automatic void ref_shift(input logic [63:0] din, input int w, input int amt,
                                    input logic [1:0] op, output logic [63:0] res,
                                    output logic st);
    logic [63:0] mask;
    logic [63:0] d;
    logic        sign;
    int          k;
    mask = (w >= 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
    d    = din & mask;
    sign = ((d >> (w - 1)) & 64'd1) != 64'd0;
    if (op == OP_ROR) begin
      k   = amt % w;
      res = ((d >> k) | (d << (w - k))) & mask;
      st  = 1'b0;
    end else if (amt >= w) begin
      res = ((op == OP_ASR) && sign) ? mask : 64'd0;
      st  = |d;
    end else if (op == OP_LSL) begin
      res = (d << amt) & mask;
      st  = |(d & ~(mask >> amt));
    end else begin
      res = d >> amt;
      if ((op == OP_ASR) && sign) res = res | (mask & ~(mask >> amt));
      st  = |(d & ~(~64'd0 << amt));
    end
  endfunction

  // One beat into an idle pipe; expects out_valid two cycles after the accept cycle.
  task automatic send_one(input vec_t v, input logic [3:0] tag, input string nm);
    int lat;
    in_valid = 1'b1;
    in_data  = v.d;
    in_amt   = AW'(v.amt);
    in_op    = v.op;
    in_tag   = tag;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) lat = c;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd2);
    chk({nm, "_data"},    64'(out_data),   64'(v.ed));
    chk({nm, "_sticky"},  64'(out_sticky), 64'(v.es));
    chk({nm, "_zero"},    64'(out_zero),   64'(v.ez));
    chk({nm, "_tag"},     64'(out_tag),    64'(tag));
    @(posedge clk); #1;
  endtask

  vec_t vecs[14];

  initial begin
    exp_t        sq[$];
    exp_t        e;
    logic [63:0] rr;
    logic        rs;
    logic        held_v;
    logic [15:0] hd;
    logic [3:0]  ht;
    logic        stale;
    int          sent;
    int          got;

    vecs[0]  = '{OP_ASR, 16'h8001,  1, 16'hC000, 1'b1, 1'b0};
    vecs[1]  = '{OP_ASR, 16'h8000, 20, 16'hFFFF, 1'b1, 1'b0};
    vecs[2]  = '{OP_LSR, 16'h0000, 20, 16'h0000, 1'b0, 1'b1};
    vecs[3]  = '{OP_LSL, 16'h8001,  1, 16'h0002, 1'b1, 1'b0};
    vecs[4]  = '{OP_ROR, 16'h1234,  4, 16'h4123, 1'b0, 1'b0};
    vecs[5]  = '{OP_ROR, 16'h1234, 20, 16'h4123, 1'b0, 1'b0};
    vecs[6]  = '{OP_LSR, 16'hABCD,  0, 16'hABCD, 1'b0, 1'b0};
    vecs[7]  = '{OP_LSR, 16'h00FF,  4, 16'h000F, 1'b1, 1'b0};
    vecs[8]  = '{OP_LSL, 16'h8001, 16, 16'h0000, 1'b1, 1'b1};
    vecs[9]  = '{OP_ASR, 16'h7FFF, 31, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{OP_ROR, 16'h1234, 16, 16'h1234, 1'b0, 1'b0};
    vecs[11] = '{OP_LSR, 16'h8000, 15, 16'h0001, 1'b0, 1'b0};
    vecs[12] = '{OP_ASR, 16'h8000, 15, 16'hFFFF, 1'b0, 1'b0};
    vecs[13] = '{OP_LSL, 16'h0001, 15, 16'h8000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_amt = 5'd0;
    in_op = OP_LSR; in_tag = 4'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid",  64'(out_valid),  64'd0);
    chk("reset_out_data",   64'(out_data),   64'd0);
    chk("reset_out_sticky", 64'(out_sticky), 64'd0);
    chk("reset_out_zero",   64'(out_zero),   64'd0);
    chk("reset_out_tag",    64'(out_tag),    64'd0);
    chk("reset_in_ready",   64'(in_ready),   64'd1);

    for (int i = 0; i < 14; i++) begin
      send_one(vecs[i], 4'(i), $sformatf("vec%0d", i));
    end

    // Stream of 8 beats with a 3-cycle output stall.
    sent = 0; got = 0; held_v = 1'b0; hd = 16'h0000; ht = 4'd0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      out_ready = !(c >= 4 && c < 7);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_data  = 16'($urandom());
        in_op    = 2'(sent % 4);
        in_amt   = AW'($urandom_range(0, 31));
        in_tag   = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      if (held_v && out_valid) begin
        chk("stream_hold_data", 64'(out_data), 64'(hd));
        chk("stream_hold_tag",  64'(out_tag),  64'(ht));
      end
      if (c == 5) chk("stream_in_ready_stall", 64'(in_ready), 64'd0);
      @(negedge clk);
      held_v = out_valid && !out_ready;
      hd = out_data;
      ht = out_tag;
      if (in_valid && in_ready) begin
        ref_shift(64'(in_data), W, int'(in_amt), in_op, rr, rs);
        e.d = rr; e.s = rs; e.z = (rr == 64'd0); e.tag = in_tag;
        sq.push_back(e);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_unexpected: actual tag=%0h expected no output", out_tag);
        end else begin
          e = sq.pop_front();
          chk("stream_data",   64'(out_data),   e.d);
          chk("stream_sticky", 64'(out_sticky), 64'(e.s));
          chk("stream_zero",   64'(out_zero),   64'(e.z));
          chk("stream_tag",    64'(out_tag),    64'(e.tag));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 64'(got), 64'd8);

    // Reset with two beats in flight.
    in_valid = 1'b1; in_data = 16'h00F0; in_amt = 5'd4; in_op = OP_LSR; in_tag = 4'hA;
    @(posedge clk); #1;
    in_data = 16'h0F00; in_tag = 4'hB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data",  64'(out_data),  64'd0);
    chk("midrst_out_tag",   64'(out_tag),   64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    stale = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);
    send_one(vecs[0], 4'h5, "post_rst");

    for (int c = 0; c < 20000 && !(g_rnd[0].done_g && g_rnd[1].done_g && g_rnd[2].done_g); c++) begin
      @(posedge clk);
    end
    chk("rnd_all_done", 64'(g_rnd[0].done_g && g_rnd[1].done_g && g_rnd[2].done_g), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Randomized traffic at three more widths, each with its own DUT.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int RW = (gi == 0) ? 8 : ((gi == 1) ? 32 : 64);
    localparam int RA = $clog2(RW) + 1;
    localparam int NB = 300;

    logic          r_rst;
    logic          r_iv;
    logic          r_ir;
    logic [RW-1:0] r_id;
    logic [RA-1:0] r_amt;
    logic [1:0]    r_op;
    logic [3:0]    r_it;
    logic          r_ov;
    logic          r_or;
    logic [RW-1:0] r_od;
    logic          r_os;
    logic          r_oz;
    logic [3:0]    r_ot;
    bit            done_g = 1'b0;

    fpu_shift_pipe #(.WIDTH(RW), .TAG_W(4)) u_dut (
      .clk(clk), .rst(r_rst),
      .in_valid(r_iv), .in_ready(r_ir), .in_data(r_id),
      .in_amt(r_amt), .in_op(r_op), .in_tag(r_it),
      .out_valid(r_ov), .out_ready(r_or), .out_data(r_od),
      .out_sticky(r_os), .out_zero(r_oz), .out_tag(r_ot)
    );

    initial begin
      exp_t        q[$];
      exp_t        e;
      logic [63:0] rd;
      logic [63:0] rr;
      logic        rs;
      int          ra;
      int          sent;
      int          cyc;
      r_rst = 1'b1; r_iv = 1'b0; r_id = {RW{1'b0}}; r_amt = {RA{1'b0}};
      r_op = OP_LSR; r_it = 4'd0; r_or = 1'b0;
      repeat (3) @(posedge clk);
      #1 r_rst = 1'b0;
      sent = 0; cyc = 0; ra = 0;
      while ((sent < NB || q.size() != 0) && cyc < 3000) begin
        r_iv  = (sent < NB) && ($urandom_range(0, 3) != 0);
        rd    = {$urandom(), $urandom()};
        r_id  = rd[RW-1:0];
        ra    = int'($urandom_range(0, 2 * RW - 1));
        r_amt = RA'(ra);
        r_op  = 2'($urandom_range(0, 3));
        r_it  = 4'($urandom_range(0, 15));
        r_or  = (sent >= NB) || ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (r_iv && r_ir) begin
          ref_shift(64'(r_id), RW, ra, r_op, rr, rs);
          e.d = rr; e.s = rs; e.z = (rr == 64'd0); e.tag = r_it;
          q.push_back(e);
          sent++;
        end
        if (r_ov && r_or) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rnd%0d_unexpected: actual tag=%0h expected no output", RW, r_ot);
          end else begin
            e = q.pop_front();
            chk($sformatf("rnd%0d_data", RW),   64'(r_od), e.d);
            chk($sformatf("rnd%0d_sticky", RW), 64'(r_os), 64'(e.s));
            chk($sformatf("rnd%0d_zero", RW),   64'(r_oz), 64'(e.z));
            chk($sformatf("rnd%0d_tag", RW),    64'(r_ot), 64'(e.tag));
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
      chk($sformatf("rnd%0d_sent", RW),    64'(sent), 64'(NB));
      chk($sformatf("rnd%0d_drained", RW), 64'(q.size()), 64'd0);
      done_g = 1'b1;
    end
  end

endmodule
